// File: rtl/hilo_pkg.sv
// HI/LO controller shared types: opcodes, FSM states, default abort limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DRAIN   = 2'd3
  } hilo_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Ops that need a multi-cycle unit and therefore an idle controller.
  function automatic logic is_muldiv(input hilo_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that touch HI/LO directly and must not race a running unit.
  function automatic logic is_xfer(input hilo_op_t op);
    return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// HI/LO architectural storage with unit-result / MTHI-MTLO write mux and MFHI/MFLO read mux.
// Latency: writes land at the next clk edge; read is combinational.
// Backpressure: none; the controller only enables writes/reads when they are legal.
module hilo_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_res_we,
  input  logic [31:0] i_res_hi,
  input  logic [31:0] i_res_lo,
  input  logic        i_mthi_we,
  input  logic        i_mtlo_we,
  input  logic [31:0] i_mt_dat,
  input  logic        i_rd_en,
  input  logic        i_rd_hi,
  output logic [31:0] o_rd_dat
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Unit results and MTHI/MTLO come from disjoint FSM states, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_res_we) begin
      r_hi <= i_res_hi;
      r_lo <= i_res_lo;
    end else begin
      if (i_mthi_we) r_hi <= i_mt_dat;
      if (i_mtlo_we) r_lo <= i_mt_dat;
    end
  end

  // Read data is forced to zero unless an MFHI/MFLO is actually accepted.
  always_comb begin
    o_rd_dat = '0;
    if (i_rd_en) o_rd_dat = i_rd_hi ? r_hi : r_lo;
  end

endmodule

// File: rtl/hilo_controller.sv
// Sequences the shared Mult/Div units and owns HI/LO; serves MFHI/MFLO/MTHI/MTLO.
// Latency: MFHI/MFLO same cycle; MULT/DIV occupy unit latency + 1 drain cycle.
// Backpressure: combinational stall holds the decode stage while HI/LO are pending.
module hilo_controller
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  hilo_op_t    op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] unit_src_a,
  output logic [31:0] unit_src_b,
  output logic        unit_sign,
  output logic        mult_valid_in,
  input  logic        mult_valid_out,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_valid_in,
  input  logic        div_valid_out,
  input  logic [31:0] div_rem,
  input  logic [31:0] div_quot,
  output logic        busy,
  output logic        timeout_err
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  hilo_state_t r_state;
  hilo_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0]   r_unit_src_a;
  logic [31:0]   r_unit_src_b;
  logic          r_unit_sign;
  logic          r_mult_vld_in;
  logic          r_div_vld_in;
  logic          r_timeout_err;

  logic w_run;
  logic w_accept;
  logic w_start_mul;
  logic w_start_div;
  logic w_done;
  logic w_timeout;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_run = (r_state == MUL_RUN) || (r_state == DIV_RUN);

  // Unit ops wait for IDLE; HI/LO transfers only wait while a unit is running.
  assign stall = op_valid &&
                 ((is_muldiv(op_code) && (r_state != IDLE)) ||
                  (is_xfer(op_code) && w_run));

  assign w_accept    = op_valid && !stall && (op_code != OP_NONE);
  assign w_start_mul = w_accept && ((op_code == OP_MULT) || (op_code == OP_MULTU));
  // Divide by zero is accepted but never starts the unit; HI/LO stay as they are.
  assign w_start_div = w_accept && ((op_code == OP_DIV) || (op_code == OP_DIVU)) &&
                       (src_b != 32'd0);

  // Only the unit owning the current RUN state may complete it.
  assign w_done    = ((r_state == MUL_RUN) && mult_valid_out) ||
                     ((r_state == DIV_RUN) && div_valid_out);
  // A result on the last allowed cycle still counts; abort only without one.
  assign w_timeout = w_run && !w_done && (r_cnt == CNT_MAX);

  assign w_res_hi = (r_state == MUL_RUN) ? mult_hi : div_rem;
  assign w_res_lo = (r_state == MUL_RUN) ? mult_lo : div_quot;

  // Next-state and RUN cycle counter (counter holds the number of RUN cycles so far, including this one).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_start_mul) begin
          w_state_nxt = MUL_RUN;
          w_cnt_nxt   = CW'(1);
        end else if (w_start_div) begin
          w_state_nxt = DIV_RUN;
          w_cnt_nxt   = CW'(1);
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (w_done || w_timeout) w_state_nxt = DRAIN;
        else                     w_cnt_nxt   = r_cnt + CW'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand latch, registered unit valids (high exactly in the matching RUN state), sticky abort flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_unit_src_a  <= '0;
      r_unit_src_b  <= '0;
      r_unit_sign   <= 1'b0;
      r_mult_vld_in <= 1'b0;
      r_div_vld_in  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start_mul || w_start_div) begin
        r_unit_src_a <= src_a;
        r_unit_src_b <= src_b;
        r_unit_sign  <= (op_code == OP_MULT) || (op_code == OP_DIV);
      end
      r_mult_vld_in <= (w_state_nxt == MUL_RUN);
      r_div_vld_in  <= (w_state_nxt == DIV_RUN);
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  hilo_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_res_we  (w_done),
    .i_res_hi  (w_res_hi),
    .i_res_lo  (w_res_lo),
    .i_mthi_we (w_accept && (op_code == OP_MTHI)),
    .i_mtlo_we (w_accept && (op_code == OP_MTLO)),
    .i_mt_dat  (src_a),
    .i_rd_en   (w_accept && ((op_code == OP_MFHI) || (op_code == OP_MFLO))),
    .i_rd_hi   (op_code == OP_MFHI),
    .o_rd_dat  (rd_data)
  );

  assign unit_src_a    = r_unit_src_a;
  assign unit_src_b    = r_unit_src_b;
  assign unit_sign     = r_unit_sign;
  assign mult_valid_in = r_mult_vld_in;
  assign div_valid_in  = r_div_vld_in;
  assign busy          = (r_state != IDLE);
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_hilo_controller.sv
// Bench for hilo_controller with behavioural Mult/Div mocks and a HI/LO scoreboard.
// Latency: mock units answer after a programmable number of valid_in cycles (0 = never).
// Backpressure: stimulus is re-driven by scenario tasks while stall is high.
module tb_hilo_controller;
  import hilo_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  hilo_op_t    op_code = OP_NONE;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] unit_src_a;
  logic [31:0] unit_src_b;
  logic        unit_sign;
  logic        mult_valid_in;
  logic        mult_valid_out = 1'b0;
  logic [31:0] mult_hi = '0;
  logic [31:0] mult_lo = '0;
  logic        div_valid_in;
  logic        div_valid_out = 1'b0;
  logic [31:0] div_rem = '0;
  logic [31:0] div_quot = '0;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Mock-unit controls and scoreboard of architectural HI/LO.
  int          mul_lat = 1;
  int          div_lat = 1;
  logic        mul_force = 1'b0;
  logic        div_force = 1'b0;
  logic        junk = 1'b0;
  int          m_cnt = 0;
  int          d_cnt = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  hilo_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .stall(stall), .rd_data(rd_data),
    .unit_src_a(unit_src_a), .unit_src_b(unit_src_b), .unit_sign(unit_sign),
    .mult_valid_in(mult_valid_in), .mult_valid_out(mult_valid_out),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_valid_in(div_valid_in), .div_valid_out(div_valid_out),
    .div_rem(div_rem), .div_quot(div_quot),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // {HI,LO} of a 32x32 product: sign/zero extend to 64 bits and keep the low 64 bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // {remainder,quotient}; guards keep the mocks safe on stale operands.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int sa, sb;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
      sa = a; sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Mock units: pulse valid_out on the lat-th cycle of valid_in, or on a forced stray pulse.
  always @(negedge clk) begin
    m_cnt = mult_valid_in ? m_cnt + 1 : 0;
    d_cnt = div_valid_in ? d_cnt + 1 : 0;
    mult_valid_out = (mult_valid_in && mul_lat != 0 && m_cnt == mul_lat) || mul_force;
    div_valid_out  = (div_valid_in && div_lat != 0 && d_cnt == div_lat) || div_force;
    {mult_hi, mult_lo} = junk ? 64'hDEAD_BEEF_CAFE_F00D : ref_mul(unit_src_a, unit_src_b, unit_sign);
    {div_rem, div_quot} = junk ? 64'hBAD0_0BAD_0DD0_D00D : ref_div(unit_src_a, unit_src_b, unit_sign);
  end

  // One decode-stage cycle: present an op at negedge, leave the bench #1 later for sampling.
  task automatic drive(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = (op != OP_NONE);
    op_code  = op;
    src_a    = a;
    src_b    = b;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, stall, mult_valid_in, div_valid_in, timeout_err, unit_sign} !== 6'b0 ||
        unit_src_a !== 32'd0 || unit_src_b !== 32'd0)
      begin n_fail++; $display("FAIL reset_outputs: flags=%b a=%h b=%h, need all zero",
        {busy, stall, mult_valid_in, div_valid_in, timeout_err, unit_sign}, unit_src_a, unit_src_b); end
    @(negedge clk);
    reset = 1'b0;
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (stall !== 1'b0 || rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_hi: stall=%b rd=%h, need 0/0", stall, rd_data); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_lo: rd=%h, need 0", rd_data); end
  endtask

  // Full MULT/DIV sequence with per-cycle handshake checks and HI/LO readback.
  task automatic run_op_checked(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b, input int lat);
    logic [63:0] exp;
    logic is_mul, sgn;
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    sgn    = (op == OP_MULT) || (op == OP_DIV);
    exp    = is_mul ? ref_mul(a, b, sgn) : ref_div(a, b, sgn);
    if (is_mul) mul_lat = lat; else div_lat = lat;
    drive(op, a, b);
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL accept op%0d: stall=%b busy=%b, need 0/0", op, stall, busy); end
    for (int k = 1; k <= lat; k++) begin
      drive(OP_NONE, 0, 0);
      n_checks++;
      if ({busy, mult_valid_in, div_valid_in} !== {1'b1, is_mul, !is_mul})
        begin n_fail++; $display("FAIL run_flags op%0d cyc%0d: %b, need %b", op, k,
          {busy, mult_valid_in, div_valid_in}, {1'b1, is_mul, !is_mul}); end
    end
    n_checks++;
    if ({unit_src_a, unit_src_b, unit_sign} !== {a, b, sgn})
      begin n_fail++; $display("FAIL unit_operands op%0d: %h %h %b, need %h %h %b", op, unit_src_a, unit_src_b, unit_sign, a, b, sgn); end
    drive(OP_NONE, 0, 0);
    n_checks++;
    if ({busy, mult_valid_in, div_valid_in} !== 3'b100)
      begin n_fail++; $display("FAIL drain_flags op%0d: %b, need 100", op, {busy, mult_valid_in, div_valid_in}); end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (stall !== 1'b0 || rd_data !== model_hi) begin n_fail++; $display("FAIL result_hi op%0d a=%h b=%h: stall=%b rd=%h, need 0 %h", op, a, b, stall, rd_data, model_hi); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (stall !== 1'b0 || rd_data !== model_lo) begin n_fail++; $display("FAIL result_lo op%0d a=%h b=%h: stall=%b rd=%h, need 0 %h", op, a, b, stall, rd_data, model_lo); end
  endtask

  task automatic test_mult_signed;
    run_op_checked(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5);
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_vec_hi: rd=%h, need ffffffff", rd_data); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_vec_lo: rd=%h, need fffffffa", rd_data); end
  endtask

  task automatic test_multu_mfhi_stall;
    int stalls;
    stalls  = 0;
    mul_lat = 4;
    drive(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    for (int k = 0; k < 4; k++) begin
      drive(OP_MFHI, 0, 0);
      if (stall === 1'b1) stalls++;
    end
    n_checks++;
    if (stalls != 4) begin n_fail++; $display("FAIL mfhi_stall_cycles: %0d, need 4", stalls); end
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b1 || rd_data !== 32'h0000_0002)
      begin n_fail++; $display("FAIL mfhi_in_drain: stall=%b busy=%b rd=%h, need 0 1 00000002", stall, busy, rd_data); end
    model_hi = 32'h0000_0002;
    model_lo = 32'hFFFF_FFFA;
    drive(OP_NONE, 0, 0);
  endtask

  task automatic test_div_zero;
    drive(OP_DIV, 32'd7, 32'd0);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL divz_stall: %b, need 0", stall); end
    drive(OP_NONE, 0, 0);
    n_checks++;
    if ({busy, div_valid_in, mult_valid_in} !== 3'b000) begin n_fail++; $display("FAIL divz_idle: %b, need 000", {busy, div_valid_in, mult_valid_in}); end
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (rd_data !== model_hi) begin n_fail++; $display("FAIL divz_hi: rd=%h, need %h", rd_data, model_hi); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== model_lo) begin n_fail++; $display("FAIL divz_lo: rd=%h, need %h", rd_data, model_lo); end
  endtask

  task automatic test_mthi_mfhi;
    logic [31:0] v;
    v = $urandom;
    drive(OP_MTHI, 32'h1234_5678, 0);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: %b, need 0", stall); end
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (stall !== 1'b0 || rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_read: stall=%b rd=%h, need 0 12345678", stall, rd_data); end
    drive(OP_MTLO, v, 0);
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== v) begin n_fail++; $display("FAIL mtlo_read: rd=%h, need %h", rd_data, v); end
    model_hi = 32'h1234_5678;
    model_lo = v;
  endtask

  task automatic test_stray_valid_out;
    logic [63:0] p;
    junk = 1'b1; mul_force = 1'b1; div_force = 1'b1;
    drive(OP_NONE, 0, 0);
    junk = 1'b0; mul_force = 1'b0; div_force = 1'b0;
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (rd_data !== model_hi) begin n_fail++; $display("FAIL stray_idle_hi: rd=%h, need %h", rd_data, model_hi); end
    mul_lat = 3;
    drive(OP_MULT, 32'h0000_1234, 32'hFFFF_0001);
    junk = 1'b1; div_force = 1'b1;
    drive(OP_NONE, 0, 0);
    junk = 1'b0; div_force = 1'b0;
    drive(OP_NONE, 0, 0);
    n_checks++;
    if ({busy, mult_valid_in} !== 2'b11) begin n_fail++; $display("FAIL stray_div_in_mul: %b, need 11", {busy, mult_valid_in}); end
    drive(OP_NONE, 0, 0);
    drive(OP_NONE, 0, 0);
    p = ref_mul(32'h0000_1234, 32'hFFFF_0001, 1'b1);
    model_hi = p[63:32]; model_lo = p[31:0];
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== model_lo) begin n_fail++; $display("FAIL stray_mul_lo: rd=%h, need %h", rd_data, model_lo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] c, d, e;
    logic [63:0] p;
    c = $urandom; d = $urandom; e = $urandom;
    mul_lat = 2;
    drive(OP_MULT, $urandom, $urandom);
    drive(OP_NONE, 0, 0);
    drive(OP_NONE, 0, 0);
    drive(OP_MULTU, c, d);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_mul_in_drain: stall=%b, need 1", stall); end
    drive(OP_MULTU, c, d);
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: stall=%b busy=%b, need 0 0", stall, busy); end
    drive(OP_NONE, 0, 0);
    drive(OP_NONE, 0, 0);
    drive(OP_MTLO, e, 0);
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_mtlo_drain: stall=%b busy=%b, need 0 1", stall, busy); end
    p = ref_mul(c, d, 1'b0);
    model_hi = p[63:32]; model_lo = e;
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (rd_data !== model_hi) begin n_fail++; $display("FAIL b2b_hi: rd=%h, need %h", rd_data, model_hi); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== model_lo) begin n_fail++; $display("FAIL b2b_lo: rd=%h, need %h", rd_data, model_lo); end
  endtask

  task automatic test_random;
    hilo_op_t ops[4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    logic [31:0] a, b;
    int kind;
    for (int i = 0; i < 25; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd5;
      if (kind < 4) begin
        run_op_checked(ops[kind], a, b, $urandom_range(1, TMO));
      end else begin
        drive(OP_MTHI, a, 0);
        drive(OP_MTLO, b, 0);
        model_hi = a; model_lo = b;
        drive(OP_MFHI, 0, 0);
        n_checks++;
        if (rd_data !== model_hi) begin n_fail++; $display("FAIL rand_mt_hi #%0d: rd=%h, need %h", i, rd_data, model_hi); end
      end
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rand_no_err: timeout_err=%b, need 0", timeout_err); end
  endtask

  task automatic test_timeout_boundary;
    run_op_checked(OP_DIVU, 32'hFFFF_FFF0, 32'd7, TMO);
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL boundary_err: timeout_err=%b, need 0", timeout_err); end
  endtask

  task automatic test_timeout;
    mul_lat = 0;
    drive(OP_MULT, 32'h7777_0000, 32'h0000_0009);
    for (int k = 1; k <= TMO; k++) begin
      drive(OP_NONE, 0, 0);
      n_checks++;
      if ({busy, mult_valid_in} !== 2'b11) begin n_fail++; $display("FAIL tmo_run cyc%0d: %b, need 11", k, {busy, mult_valid_in}); end
    end
    drive(OP_NONE, 0, 0);
    n_checks++;
    if ({busy, mult_valid_in, timeout_err} !== 3'b101)
      begin n_fail++; $display("FAIL tmo_drain: busy/mvi/err=%b, need 101", {busy, mult_valid_in, timeout_err}); end
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (rd_data !== model_hi) begin n_fail++; $display("FAIL tmo_hi_kept: rd=%h, need %h", rd_data, model_hi); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== model_lo || timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_lo_kept: rd=%h err=%b, need %h 1", rd_data, timeout_err, model_lo); end
  endtask

  task automatic test_reset_mid;
    mul_lat = 0;
    drive(OP_MULT, 32'h0000_0100, 32'h0000_0100);
    repeat (3) drive(OP_NONE, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, mult_valid_in, div_valid_in, timeout_err} !== 4'b0000)
      begin n_fail++; $display("FAIL reset_mid_flags: %b, need 0000", {busy, mult_valid_in, div_valid_in, timeout_err}); end
    @(negedge clk);
    reset = 1'b0;
    junk = 1'b1; mul_force = 1'b1;
    drive(OP_NONE, 0, 0);
    junk = 1'b0; mul_force = 1'b0;
    model_hi = '0; model_lo = '0;
    drive(OP_MFHI, 0, 0);
    n_checks++;
    if (rd_data !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_hi: rd=%h busy=%b, need 0 0", rd_data, busy); end
    drive(OP_MFLO, 0, 0);
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_mid_lo: rd=%h, need 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_mfhi_stall();
    test_div_zero();
    test_mthi_mfhi();
    test_stray_valid_out();
    test_back_to_back();
    test_random();
    test_timeout_boundary();
    test_timeout();
    test_reset_mid();
    drive(OP_NONE, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
